// File: rtl/dmem_responder_pkg.sv
// -----------------------------------------------------------------------------
// dmem_responder_pkg
//
// Purpose: shared constants and types for the data-memory responder.
//   - default geometry (DMEM_DEPTH words of DMEM_DW bits, DMEM_AW address bits)
//   - default RESULT capture address
//   - FSM state encoding (CLEAR = 0, SERVE = 1)
//   - RW bus encoding (READ = 1, WRITE = 0)
//   - saturating increment helper for the write counter
// -----------------------------------------------------------------------------
package dmem_responder_pkg;

    localparam int DMEM_DEPTH       = 128;
    localparam int DMEM_AW          = 7;
    localparam int DMEM_RESULT_ADDR = 0;
    localparam int DMEM_DW          = 16;
    localparam int WCOUNT_W         = 8;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_SERVE = 1'b1
    } dmem_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [WCOUNT_W-1:0] sat_inc(input logic [WCOUNT_W-1:0] v);
        logic [WCOUNT_W-1:0] r;
        r = (v == {WCOUNT_W{1'b1}}) ? v : v + WCOUNT_W'(1);
        return r;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// -----------------------------------------------------------------------------
// dmem_responder_if
//
// Purpose: groups the CPU-side address/control inputs and the status outputs
// of dmem_responder. The bidirectional data bus DD is a plain inout port on
// the responder so tri-state resolution stays on ordinary nets.
//
// Bus protocol: there is no strobe. Every falling edge of CK while the
// responder is in SERVE is one transaction: RW = READ (1) reads DA, RW = WRITE
// (0) writes DD to DA. A host that wants to stay idle holds RW = READ on a
// harmless in-range address. Read data appears on DD after the edge that
// sampled the read and is held until the next falling edge.
//
// Signals:
//   DA        host -> responder   data address
//   RW        host -> responder   1 = read, 0 = write
//   RESULT    responder -> host   last value written to the result address
//   DONE      responder -> host   sticky, first result write seen
//   ERR       responder -> host   sticky, out-of-range access seen
//   BUSY      responder -> host   post-reset clear sequence running
//   WCOUNT    responder -> host   accepted writes, saturating
//   dbg_state responder -> host   FSM state (debug)
//   dbg_dd_oe responder -> host   DD output enable (debug)
// -----------------------------------------------------------------------------
interface dmem_responder_if;
    import dmem_responder_pkg::*;

    logic [DMEM_DW-1:0]  DA;
    logic                RW;
    logic [DMEM_DW-1:0]  RESULT;
    logic                DONE;
    logic                ERR;
    logic                BUSY;
    logic [WCOUNT_W-1:0] WCOUNT;
    dmem_state_e         dbg_state;
    logic                dbg_dd_oe;

    modport master (
        output DA, RW,
        input  RESULT, DONE, ERR, BUSY, WCOUNT, dbg_state, dbg_dd_oe
    );

    modport slave (
        input  DA, RW,
        output RESULT, DONE, ERR, BUSY, WCOUNT, dbg_state, dbg_dd_oe
    );

endinterface

// File: rtl/dmem_array.sv
// -----------------------------------------------------------------------------
// dmem_array
//
// Purpose: single-port data storage. Writes and reads both happen on the
// falling edge of i_clk. The read result is registered; it is only reloaded
// when i_re is high, otherwise it holds its last value.
//
// Ports:
//   i_clk      clock (falling edge active)
//   i_rst_n    asynchronous active-low reset, clears the read register only
//   i_we       write enable
//   i_re       read enable (loads the read register)
//   i_rd_zero  with i_re: load 0 instead of the addressed word
//   i_addr     word index
//   i_wdata    write data
//   o_rdata    registered read data
// -----------------------------------------------------------------------------
module dmem_array #(
    parameter int DEPTH = 128,
    parameter int AW    = 7,
    parameter int DW    = 16
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_we,
    input  logic          i_re,
    input  logic          i_rd_zero,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_rdata
);

    // Contents are not reset; the responder overwrites every word with zero
    // after each reset before it starts serving.
    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    always_ff @(negedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    always_ff @(negedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= i_rd_zero ? '0 : r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Purpose: CPU data-memory responder. After every reset it walks the whole
// array writing zeros (CLEAR, BUSY = 1, one word per falling edge), then
// serves reads and writes from the CPU bus (SERVE). Writes to RESULT_ADDR are
// mirrored into RESULT and set DONE; any out-of-range access sets ERR. All
// state changes on the falling edge of CK.
//
// Ports:
//   CK     clock, falling edge active
//   RST    asynchronous active-low reset
//   DD     bidirectional data bus, driven here only while reading in SERVE
//   bus    slave side of dmem_responder_if (DA, RW in; status out)
//
// Parameters:
//   DEPTH        number of 16-bit words
//   AW           decoded address bits, log2(DEPTH)
//   RESULT_ADDR  address whose writes are also captured in RESULT
// -----------------------------------------------------------------------------
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH       = DMEM_DEPTH,
    parameter int AW          = DMEM_AW,
    parameter int RESULT_ADDR = DMEM_RESULT_ADDR
) (
    input  logic              CK,
    input  logic              RST,
    inout  wire [DMEM_DW-1:0] DD,
    dmem_responder_if.slave   bus
);

    // FSM
    dmem_state_e          r_state;
    dmem_state_e          w_next_state;
    logic [AW-1:0]        r_clr_cnt;
    logic                 w_busy;
    logic                 w_dd_oe;

    // Address decode / access qualification
    logic                 w_in_range;
    logic [AW-1:0]        w_index;
    logic                 w_serve;
    logic                 w_wr_acc;
    logic                 w_rd_acc;
    logic                 w_is_result;

    // Array port
    logic                 w_arr_we;
    logic                 w_arr_re;
    logic                 w_arr_rd_zero;
    logic [AW-1:0]        w_arr_addr;
    logic [DMEM_DW-1:0]   w_arr_wdata;
    logic [DMEM_DW-1:0]   w_rdata;

    // Status
    logic [DMEM_DW-1:0]   r_result;
    logic                 r_done;
    logic                 r_err;
    logic [WCOUNT_W-1:0]  r_wcount;

    // -------------------------------------------------------------------------
    // Address decode
    // -------------------------------------------------------------------------
    assign w_in_range  = (bus.DA[DMEM_DW-1:AW] == '0);
    assign w_index     = bus.DA[AW-1:0];
    assign w_serve     = (r_state == ST_SERVE);
    assign w_wr_acc    = w_serve && (bus.RW == RW_WRITE) && w_in_range;
    assign w_rd_acc    = w_serve && (bus.RW == RW_READ);
    // Full 16-bit compare so an aliased out-of-range address never matches.
    assign w_is_result = (bus.DA == 16'(RESULT_ADDR));

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(negedge CK or negedge RST) begin
        if (!RST) begin
            r_state <= ST_CLEAR;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state. CLEAR leaves on the edge that zeroes the last word.
    // -------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_CLEAR: begin
                if (r_clr_cnt == AW'(DEPTH - 1)) begin
                    w_next_state = ST_SERVE;
                end
            end
            ST_SERVE: begin
                w_next_state = ST_SERVE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs. The DD enable is combinational on RW so the bus turns
    // around as soon as the host switches to a write.
    // -------------------------------------------------------------------------
    always_comb begin
        w_busy  = 1'b0;
        w_dd_oe = 1'b0;
        if (r_state == ST_CLEAR) begin
            w_busy = 1'b1;
        end else begin
            w_dd_oe = (bus.RW == RW_READ);
        end
    end

    // -------------------------------------------------------------------------
    // Clear counter: walks every index once while in CLEAR, wraps to zero on
    // the final edge and stays there during SERVE.
    // -------------------------------------------------------------------------
    always_ff @(negedge CK or negedge RST) begin
        if (!RST) begin
            r_clr_cnt <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_clr_cnt <= r_clr_cnt + AW'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Array port mux: the clear walk owns the write port while BUSY, and
    // the host bus is ignored.
    // -------------------------------------------------------------------------
    always_comb begin
        w_arr_we    = w_wr_acc;
        w_arr_addr  = w_index;
        w_arr_wdata = DD;
        if (w_busy) begin
            w_arr_we    = 1'b1;
            w_arr_addr  = r_clr_cnt;
            w_arr_wdata = '0;
        end
    end

    assign w_arr_re      = w_rd_acc;
    assign w_arr_rd_zero = !w_in_range;

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DMEM_DW)
    ) u_array (
        .i_clk     (CK),
        .i_rst_n   (RST),
        .i_we      (w_arr_we),
        .i_re      (w_arr_re),
        .i_rd_zero (w_arr_rd_zero),
        .i_addr    (w_arr_addr),
        .i_wdata   (w_arr_wdata),
        .o_rdata   (w_rdata)
    );

    // -------------------------------------------------------------------------
    // Status flags and counters. Nothing here moves during CLEAR.
    // -------------------------------------------------------------------------
    always_ff @(negedge CK or negedge RST) begin
        if (!RST) begin
            r_result <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_wcount <= '0;
        end else if (w_serve) begin
            if (w_wr_acc) begin
                r_wcount <= sat_inc(r_wcount);
                if (w_is_result) begin
                    r_result <= DD;
                    r_done   <= 1'b1;
                end
            end
            if (!w_in_range) begin
                r_err <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign DD = w_dd_oe ? w_rdata : 'z;

    assign bus.RESULT    = r_result;
    assign bus.DONE      = r_done;
    assign bus.ERR       = r_err;
    assign bus.BUSY      = w_busy;
    assign bus.WCOUNT    = r_wcount;
    assign bus.dbg_state = r_state;
    assign bus.dbg_dd_oe = w_dd_oe;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//
// Directed bench for dmem_responder. Inputs change on the rising edge, the
// DUT acts on the falling edge, and outputs are sampled 1 time unit after a
// falling edge or a rising edge. Read expectations go into exp_q when a read
// is issued; a monitor pops and compares after the falling edge that
// produces the data.
// -----------------------------------------------------------------------------
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    logic        ck;
    logic        rst_n;
    logic        tb_oe;
    logic [15:0] tb_dd;
    wire  [15:0] dd_bus;
    logic        rd_track;
    logic        mon_tagged;
    logic [15:0] mon_exp;

    logic [15:0] exp_q[$];
    int          n_vec;
    int          n_err;

    dmem_responder_if bus ();

    assign dd_bus = tb_oe ? tb_dd : 16'hzzzz;

    dmem_responder u_dut (
        .CK  (ck),
        .RST (rst_n),
        .DD  (dd_bus),
        .bus (bus)
    );

    // ---------------- clock ----------------
    initial ck = 1'b0;
    always #5 ck = ~ck;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Read monitor: a tracked read edge must leave DD driven with the
    // expected word.
    always begin
        @(negedge ck);
        mon_tagged = rd_track;
        #1;
        if (mon_tagged) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL rd_unexpected: got 0x%0h expected no read", dd_bus);
            end else begin
                mon_exp = exp_q.pop_front();
                check("rd_oe", 32'(bus.dbg_dd_oe), 32'd1);
                check("rd_data", 32'(dd_bus), 32'(mon_exp));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic go_idle();
        @(posedge ck);
        bus.DA   = 16'h0000;
        bus.RW   = RW_READ;
        tb_oe    = 1'b0;
        rd_track = 1'b0;
        #1;
    endtask

    task automatic do_write(input logic [15:0] addr, input logic [15:0] data);
        @(posedge ck);
        bus.DA   = addr;
        bus.RW   = RW_WRITE;
        tb_dd    = data;
        tb_oe    = 1'b1;
        rd_track = 1'b0;
        #1;
        check("dd_oe_on_write", 32'(bus.dbg_dd_oe), 32'd0);
        @(negedge ck);
    endtask

    task automatic do_read(input logic [15:0] addr, input logic [15:0] exp);
        @(posedge ck);
        bus.DA   = addr;
        bus.RW   = RW_READ;
        tb_oe    = 1'b0;
        rd_track = 1'b1;
        exp_q.push_back(exp);
        @(negedge ck);
    endtask

    // Counts falling edges until BUSY drops, bounded.
    task automatic wait_clear(input string name);
        int n;
        n = 0;
        while (bus.BUSY && n < 200) begin
            @(negedge ck);
            #1;
            n++;
        end
        check(name, 32'(n), 32'd128);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"},   32'(bus.BUSY),      32'd1);
        check({tag, "_wcount"}, 32'(bus.WCOUNT),    32'd0);
        check({tag, "_result"}, 32'(bus.RESULT),    32'd0);
        check({tag, "_done"},   32'(bus.DONE),      32'd0);
        check({tag, "_err"},    32'(bus.ERR),       32'd0);
        check({tag, "_oe"},     32'(bus.dbg_dd_oe), 32'd0);
        check({tag, "_state"},  32'(bus.dbg_state), 32'(ST_CLEAR));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        bus.DA   = 16'h0000;
        bus.RW   = RW_READ;
        tb_oe    = 1'b0;
        tb_dd    = 16'h0000;
        rd_track = 1'b0;
        #1;
        check_reset_state("por");

        // Clear sequence length, then a cleared word reads back zero.
        @(posedge ck);
        rst_n = 1'b1;
        wait_clear("clear_len_1");
        check("state_serve", 32'(bus.dbg_state), 32'(ST_SERVE));
        do_read(16'h0005, 16'h0000);

        // Write then immediate read of the same address.
        do_write(16'h0003, 16'hBEEF);
        do_read(16'h0003, 16'hBEEF);
        go_idle();
        check("wcount_1", 32'(bus.WCOUNT), 32'd1);
        check("done_0", 32'(bus.DONE), 32'd0);

        // Result capture.
        do_write(16'h0000, 16'h0004);
        go_idle();
        check("result_4", 32'(bus.RESULT), 32'h0004);
        check("done_1", 32'(bus.DONE), 32'd1);
        do_write(16'h0000, 16'h0009);
        go_idle();
        check("result_9", 32'(bus.RESULT), 32'h0009);
        check("done_sticky", 32'(bus.DONE), 32'd1);
        check("wcount_3", 32'(bus.WCOUNT), 32'd3);
        check("err_0", 32'(bus.ERR), 32'd0);

        // Out-of-range write and read.
        do_write(16'h0080, 16'h1234);
        go_idle();
        check("err_1", 32'(bus.ERR), 32'd1);
        check("wcount_oor", 32'(bus.WCOUNT), 32'd3);
        check("result_oor", 32'(bus.RESULT), 32'h0009);
        do_read(16'h0000, 16'h0009);
        do_read(16'h0080, 16'h0000);
        do_read(16'h0003, 16'hBEEF);
        go_idle();
        check("err_sticky", 32'(bus.ERR), 32'd1);

        // 300 writes to addresses 10..109; WCOUNT saturates.
        for (int i = 0; i < 300; i++) begin
            do_write(16'((i % 100) + 10), 16'hA000 + 16'(i));
        end
        go_idle();
        check("wcount_sat", 32'(bus.WCOUNT), 32'd255);
        do_read(16'd20, 16'hA0D2);
        do_read(16'd109, 16'hA12B);
        go_idle();
        check("result_kept", 32'(bus.RESULT), 32'h0009);

        // Reset during SERVE.
        @(posedge ck);
        rst_n = 1'b0;
        #1;
        check_reset_state("rst_serve");
        @(posedge ck);
        rst_n = 1'b1;
        wait_clear("clear_len_2");
        do_read(16'h0003, 16'h0000);
        do_read(16'd20, 16'h0000);
        go_idle();

        // Reset mid-CLEAR while the host attempts writes; they must be ignored.
        @(posedge ck);
        rst_n = 1'b0;
        #1;
        check_reset_state("rst_clear_a");
        bus.DA = 16'h0000;
        bus.RW = RW_WRITE;
        tb_dd  = 16'h5555;
        tb_oe  = 1'b1;
        @(posedge ck);
        rst_n = 1'b1;
        repeat (50) @(negedge ck);
        @(posedge ck);
        rst_n = 1'b0;
        #1;
        check_reset_state("rst_clear_b");
        @(posedge ck);
        rst_n = 1'b1;
        wait_clear("clear_len_3");
        // Back to idle before the first SERVE edge.
        bus.RW = RW_READ;
        tb_oe  = 1'b0;
        check("clr_wcount", 32'(bus.WCOUNT), 32'd0);
        check("clr_done", 32'(bus.DONE), 32'd0);
        check("clr_result", 32'(bus.RESULT), 32'd0);
        do_read(16'h0000, 16'h0000);
        go_idle();
        check("final_wcount", 32'(bus.WCOUNT), 32'd0);

        repeat (2) @(negedge ck);
        check("scoreboard_drain", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
